// File: rtl/alu_pkg.sv
// Shared types, constants and the CRC3 helper for the ALU output stage.
package alu_pkg;

  localparam int unsigned FRAME_BITS    = 11;
  localparam int unsigned RESULT_FRAMES = 5;
  localparam int unsigned ERR_FRAMES    = 1;

  // err_flags layout: {ERR_DATA,ERR_CRC,ERR_OP} twice, high copy first
  localparam int unsigned ERR_OP_LO   = 0;
  localparam int unsigned ERR_CRC_LO  = 1;
  localparam int unsigned ERR_DATA_LO = 2;
  localparam int unsigned ERR_OP_HI   = 3;
  localparam int unsigned ERR_CRC_HI  = 4;
  localparam int unsigned ERR_DATA_HI = 5;

  typedef enum logic {
    TT_DATA = 1'b0,
    TT_CTL  = 1'b1
  } transfer_type_t;

  typedef struct packed {
    transfer_type_t ftype;
    logic [7:0]     data;
  } frame_t;

  // CRC3, poly x^3+x+1, init 0, non-reflected, MSB first
  function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_tx_frame.sv
// Shifts one 11-bit frame {start,type,data[7:0],stop} onto sout at CLKS_PER_BIT pacing.
module alu_tx_frame
  import alu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  frame_t frame,
  output logic   sout,
  output logic   frame_done_c,
  output logic   pre_done_c
);

  localparam int unsigned BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W    = 4;
  localparam int unsigned LAST_BIT = FRAME_BITS - 1;
  // Cycle just before the final stop-bit cycle
  localparam int unsigned PRE_BIT  = (CLKS_PER_BIT == 1) ? LAST_BIT - 1 : LAST_BIT;
  localparam int unsigned PRE_BAUD = (CLKS_PER_BIT == 1) ? 0 : CLKS_PER_BIT - 2;

  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-2:0] rest;
  logic                  active;
  logic                  baud_end_c;

  assign baud_end_c   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign frame_done_c = active && baud_end_c && (bit_cnt == BIT_W'(LAST_BIT));
  assign pre_done_c   = active && (bit_cnt == BIT_W'(PRE_BIT)) &&
                        (baud_cnt == BAUD_W'(PRE_BAUD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sout     <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rest     <= '1;
    end else if (load) begin
      sout     <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rest     <= {frame.ftype, frame.data, 1'b1};
    end else if (active) begin
      if (!baud_end_c) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        if (bit_cnt == BIT_W'(LAST_BIT)) begin
          active  <= 1'b0;
          sout    <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          sout    <= rest[FRAME_BITS-2];
          rest    <= {rest[FRAME_BITS-3:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/alu_sout_serializer.sv
// ALU output stage: accepts a result or error, sequences its frames onto sout.
module alu_sout_serializer
  import alu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] c_in,
  input  logic [3:0]  flags_in,
  input  logic        err_in,
  input  logic [5:0]  err_flags,
  output logic        sout,
  output logic        busy
);

  localparam int unsigned FCNT_W = 3;
  localparam logic [FCNT_W-1:0] LAST_RESULT = FCNT_W'(RESULT_FRAMES - 1);
  localparam logic [FCNT_W-1:0] LAST_ERR    = FCNT_W'(ERR_FRAMES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [FCNT_W-1:0] frame_cnt, frame_cnt_d;
  logic              in_ready_d;
  logic [31:0]       c_q;
  logic [3:0]        flags_q;
  logic              err_q;

  logic              accept_c;
  logic              load_c;
  frame_t            load_frame_c;
  logic [FCNT_W-1:0] last_idx_c;
  logic [2:0]        crc_c;
  logic [7:0]        err_byte_c;
  logic              frame_done_c;
  logic              pre_done_c;

  assign crc_c      = crc3_calc({c_q, 1'b0, flags_q});
  assign last_idx_c = err_q ? LAST_ERR : LAST_RESULT;
  assign busy       = ~in_ready;

  // Error payload goes straight into the shifter, so it is built from the live inputs
  always_comb begin
    err_byte_c      = {1'b1, err_flags[ERR_DATA_HI], err_flags[ERR_CRC_HI], err_flags[ERR_OP_HI],
                       err_flags[ERR_DATA_LO], err_flags[ERR_CRC_LO], err_flags[ERR_OP_LO], 1'b0};
    err_byte_c[0]   = ^err_byte_c[7:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      in_ready  <= 1'b1;
      c_q       <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      frame_cnt <= frame_cnt_d;
      in_ready  <= in_ready_d;
      if (accept_c) begin
        c_q     <= c_in;
        flags_q <= flags_in;
        err_q   <= err_in;
      end
    end
  end

  always_comb begin
    state_d            = state;
    frame_cnt_d        = frame_cnt;
    in_ready_d         = in_ready;
    accept_c           = 1'b0;
    load_c             = 1'b0;
    load_frame_c.ftype = TT_DATA;
    load_frame_c.data  = 8'h00;
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          accept_c    = 1'b1;
          load_c      = 1'b1;
          state_d     = S_SEND;
          frame_cnt_d = '0;
          in_ready_d  = 1'b0;
          if (err_in) begin
            load_frame_c.ftype = TT_CTL;
            load_frame_c.data  = err_byte_c;
          end else begin
            load_frame_c.data  = c_in[31:24];
          end
        end
      end
      S_SEND: begin
        if (frame_cnt > last_idx_c) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end else if (frame_cnt == last_idx_c) begin
          // Release the handshake for the final stop-bit cycle so a new start bit can follow directly
          if (pre_done_c) begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
          end
        end else if (frame_done_c) begin
          load_c      = 1'b1;
          frame_cnt_d = frame_cnt + 1'b1;
          case (frame_cnt)
            3'd0:    load_frame_c.data = c_q[23:16];
            3'd1:    load_frame_c.data = c_q[15:8];
            3'd2:    load_frame_c.data = c_q[7:0];
            default: begin
              load_frame_c.ftype = TT_CTL;
              load_frame_c.data  = {1'b0, flags_q, crc_c};
            end
          endcase
        end
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  alu_tx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .load        (load_c),
    .frame       (load_frame_c),
    .sout        (sout),
    .frame_done_c(frame_done_c),
    .pre_done_c  (pre_done_c)
  );

endmodule

// File: tb/tb_alu_sout_serializer.sv
// Bench for alu_sout_serializer: per-cycle bit-stream model for CLKS_PER_BIT=1 and 4 plus literal frame checks.
module tb_alu_sout_serializer;

  typedef bit bitq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        err_in = 1'b0;
  logic [31:0] c_in = '0;
  logic [3:0]  flags_in = '0;
  logic [5:0]  err_flags = '0;
  logic        in_ready0, sout0, busy0;
  logic        in_ready1, sout1, busy1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sout_serializer #(.CLKS_PER_BIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .c_in(c_in),
    .flags_in(flags_in), .err_in(err_in), .err_flags(err_flags), .sout(sout0), .busy(busy0)
  );

  alu_sout_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .c_in(c_in),
    .flags_in(flags_in), .err_in(err_in), .err_flags(err_flags), .sout(sout1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // CRC as remainder of M(x)*x^3 mod (x^3+x+1)
  function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [10:0] frame_bits(input logic t, input logic [7:0] d);
    return {1'b0, t, d, 1'b1};
  endfunction

  // Whole response as one sout value per clock
  function automatic bitq_t response(input logic [31:0] c, input logic [3:0] f, input logic e,
                                     input logic [5:0] ef, input int cpb);
    bitq_t       q;
    logic [10:0] fr [5];
    int          n;
    logic        p;
    if (e) begin
      p     = ($countones({1'b1, ef}) % 2) == 1;
      fr[0] = frame_bits(1'b1, {1'b1, ef, p});
      n     = 1;
    end else begin
      for (int k = 0; k < 4; k++) fr[k] = frame_bits(1'b0, c[31-8*k -: 8]);
      fr[4] = frame_bits(1'b1, {1'b0, f, ref_crc(c, f)});
      n     = 5;
    end
    for (int k = 0; k < n; k++)
      for (int b = 10; b >= 0; b--)
        for (int r = 0; r < cpb; r++) q.push_back(fr[k][b]);
    return q;
  endfunction

  bitq_t q0, q1;
  logic  m_ready0 = 1'b1;
  logic  m_ready1 = 1'b1;
  bit    started = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_ready0 = 1'b1;
      m_ready1 = 1'b1;
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (in_valid && m_ready0) q0 = response(c_in, flags_in, err_in, err_flags, 1);
      m_ready0 = (q0.size() <= 1);
      if (q1.size() > 0) void'(q1.pop_front());
      if (in_valid && m_ready1) q1 = response(c_in, flags_in, err_in, err_flags, 4);
      m_ready1 = (q1.size() <= 1);
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("sout_cpb1", sout0, (q0.size() > 0) ? q0[0] : 1'b1);
      chk("in_ready_cpb1", in_ready0, m_ready0);
      chk("busy_cpb1", busy0, !m_ready0);
      chk("sout_cpb4", sout1, (q1.size() > 0) ? q1[0] : 1'b1);
      chk("in_ready_cpb4", in_ready1, m_ready1);
      chk("busy_cpb4", busy1, !m_ready1);
    end
  end

  task automatic send(input logic [31:0] c, input logic [3:0] f, input logic e, input logic [5:0] ef);
    @(negedge clk);
    c_in = c; flags_in = f; err_in = e; err_flags = ef; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_idle_timeout: still busy after %0d cycles", nm, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [54:0] cap55;
    logic [10:0] cap11;

    chk("model_crc_zero_flag", ref_crc(32'h0, 4'b0010), 3'b110);
    chk("model_crc_carry_flag", ref_crc(32'h0, 4'b1000), 3'b101);

    // Reset and idle line
    repeat (3) @(negedge clk);
    chk("rst_sout", sout0, 1'b1);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_sout", sout0, 1'b1);
    end

    // Result C=0, flags=Zero
    send(32'h0, 4'b0010, 1'b0, 6'h0);
    cap55 = '0;
    for (int k = 1; k <= 55; k++) begin
      if (k > 1) @(negedge clk);
      cap55 = {cap55[53:0], sout0};
      if (k == 54) chk("ready_before_last_stop", in_ready0, 1'b0);
      if (k == 55) chk("ready_on_last_stop", in_ready0, 1'b1);
    end
    chk("result_stream", cap55, {{4{11'b00000000001}}, 11'b01000101101});
    wait_idle("result");

    // Error frame
    send(32'h12345678, 4'hF, 1'b1, 6'b100100);
    cap11 = '0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      cap11 = {cap11[9:0], sout0};
      if (k == 11) chk("err_ready_on_stop", in_ready0, 1'b1);
    end
    chk("error_stream", cap11, 11'b01110010011);
    wait_idle("error");

    // Reset during bit 5 of frame 2 (a data-0 bit), then a clean response
    @(negedge clk);
    c_in = 32'hA5A5_0F5A; flags_in = 4'b0001; err_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (27) @(posedge clk);
    #1 chk("pre_rst_sout", sout0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_sout", sout0, 1'b1);
    chk("midrst_in_ready", in_ready0, 1'b1);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_sout_cpb4", sout1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(32'hCAFE_F00D, 4'b0101, 1'b0, 6'h0);
    wait_idle("after_reset");

    // Back-to-back with in_valid held high
    @(negedge clk);
    c_in = 32'hDEAD_BEEF; flags_in = 4'b1000; err_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    c_in = 32'h7FFF_FFFF; flags_in = 4'b0100;
    repeat (54) @(negedge clk);
    chk("b2b_ready_last_stop", in_ready0, 1'b1);
    @(negedge clk);
    chk("b2b_second_start", sout0, 1'b0);
    chk("b2b_busy_again", busy0, 1'b1);
    in_valid = 1'b0;
    wait_idle("b2b");

    // Random traffic, including valid while busy
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) == 0);
      c_in      = $urandom;
      flags_in  = 4'($urandom_range(0, 15));
      err_in    = ($urandom_range(0, 7) == 0);
      err_flags = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
